spi_master_ctrl: RTL and testbench

Synthesizable SPI master (initiator) that drives SCLK, CS, MOSI and samples MISO for one data word per transfer, in all four CPOL/CPHA modes, MSB- or LSB-first. It pairs with the slave-side driver BFM and sits between a host valid/ready word interface and the `spi_if` pins. It supports loopback against the slave BFM in `hdl_top`, and is the RTL master for future DUT-less regressions.

---
 rtl/spi_globals_pkg.sv | 20 ++
 rtl/spi_sclk_gen.sv | 50 +++++
 rtl/spi_master_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_globals_pkg.sv
// Shared state/direction types and default sizing for the SPI master controller.
package spi_globals_pkg;

   localparam int SPI_DATA_WIDTH   = 8;
   localparam int SPI_NO_OF_SLAVES = 1;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } spi_state_e;

   typedef enum logic {
      MSB_FIRST,
      LSB_FIRST
   } shift_direction_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: toggles sclk every half_period pclk cycles while enabled and
// flags whether each toggle is a leading (away from CPOL) or trailing edge.
module spi_sclk_gen #(
   parameter int DIV_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 cpol,
   input  logic [DIV_WIDTH-1:0] half_period,
   output logic                 sclk,
   output logic                 lead_stb,
   output logic                 trail_stb
);

   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic                 sclk_q, sclk_d;
   logic                 stb;

   always_comb begin
      cnt_d  = '0;
      sclk_d = cpol;
      stb    = 1'b0;
      if (en) begin
         sclk_d = sclk_q;
         if (cnt_q == half_period - DIV_WIDTH'(1)) begin
            stb    = 1'b1;
            sclk_d = ~sclk_q;
         end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

   // Strobes describe the transition launched at this pclk edge.
   assign lead_stb  = stb && (sclk_q == cpol);
   assign trail_stb = stb && (sclk_q != cpol);
   assign sclk      = sclk_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: accepts one host word, runs a CS-framed transfer in any
// CPOL/CPHA mode, MSB- or LSB-first, and returns the word sampled from MISO.
module spi_master_ctrl
   import spi_globals_pkg::*;
#(
   parameter int DATA_WIDTH   = SPI_DATA_WIDTH,
   parameter int NO_OF_SLAVES = SPI_NO_OF_SLAVES,
   parameter int DIV_WIDTH    = 8,
   parameter int SEL_WIDTH    = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1
) (
   input  logic                    pclk,
   input  logic                    areset,
   input  logic                    cfg_cpol,
   input  logic                    cfg_cpha,
   input  logic                    cfg_msb_first,
   input  logic [DIV_WIDTH-1:0]    cfg_baud_div,
   input  logic [DIV_WIDTH-1:0]    cfg_cs_delay,
   input  logic                    tx_valid,
   output logic                    tx_ready,
   input  logic [DATA_WIDTH-1:0]   tx_data,
   input  logic [SEL_WIDTH-1:0]    tx_slave_sel,
   output logic                    rx_valid,
   output logic [DATA_WIDTH-1:0]   rx_data,
   output logic                    busy,
   output logic                    sclk,
   output logic [NO_OF_SLAVES-1:0] cs,
   output logic                    mosi0,
   input  logic                    miso0
);

   localparam int                EDGE_W    = $clog2(2 * DATA_WIDTH);
   localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_WIDTH - 1);

   spi_state_e              state_q, state_d;
   shift_direction_e        dir_q, dir_d;
   logic                    cpol_q, cpol_d, cpha_q, cpha_d;
   logic [DIV_WIDTH-1:0]    div_q, div_d, dly_q, dly_d, dly_cnt_q, dly_cnt_d;
   logic [SEL_WIDTH-1:0]    sel_q, sel_d;
   logic [DATA_WIDTH-1:0]   tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
   logic [EDGE_W-1:0]       edge_q, edge_d;
   logic [NO_OF_SLAVES-1:0] cs_q, cs_d, sel_mask;
   logic                    mosi_q, mosi_d, tx_ready_q, tx_ready_d;
   logic                    rx_valid_q, rx_valid_d, busy_q, busy_d;
   logic                    lead_stb, trail_stb, edge_stb, sample, launch;
   logic                    sclk_en, gen_cpol;
   logic [DIV_WIDTH-1:0]    dly_last;

   assign sclk_en  = (state_q == SHIFT);
   assign gen_cpol = (state_q == IDLE) ? cfg_cpol : cpol_q;
   assign edge_stb = lead_stb | trail_stb;
   assign dly_last = dly_q - DIV_WIDTH'(1);

   spi_sclk_gen #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_sclk_gen (
      .clk         (pclk),
      .rst         (areset),
      .en          (sclk_en),
      .cpol        (gen_cpol),
      .half_period (div_q),
      .sclk        (sclk),
      .lead_stb    (lead_stb),
      .trail_stb   (trail_stb)
   );

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      cpol_d    = cpol_q;
      cpha_d    = cpha_q;
      div_d     = div_q;
      dly_d     = dly_q;
      dly_cnt_d = dly_cnt_q;
      sel_d     = sel_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      rx_data_d = rx_data_q;
      edge_d    = edge_q;
      mosi_d    = mosi_q;
      sample    = 1'b0;
      launch    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (tx_valid && tx_ready_q) begin
               state_d   = SETUP;
               cpol_d    = cfg_cpol;
               cpha_d    = cfg_cpha;
               dir_d     = cfg_msb_first ? MSB_FIRST : LSB_FIRST;
               div_d     = (cfg_baud_div == '0) ? DIV_WIDTH'(1) : cfg_baud_div;
               dly_d     = (cfg_cs_delay == '0) ? DIV_WIDTH'(1) : cfg_cs_delay;
               sel_d     = tx_slave_sel;
               dly_cnt_d = '0;
               edge_d    = '0;
               rx_sh_d   = '0;
               tx_sh_d   = tx_data;
               // CPHA=0 must present the first bit before the first SCLK edge.
               if (!cfg_cpha) begin
                  mosi_d  = cfg_msb_first ? tx_data[DATA_WIDTH-1] : tx_data[0];
                  tx_sh_d = cfg_msb_first ? (tx_data << 1) : (tx_data >> 1);
               end
            end
         end
         SETUP: begin
            if (dly_cnt_q == dly_last) begin
               state_d   = SHIFT;
               dly_cnt_d = '0;
            end else begin
               dly_cnt_d = dly_cnt_q + DIV_WIDTH'(1);
            end
         end
         SHIFT: begin
            if (edge_stb) begin
               sample = cpha_q ? trail_stb : lead_stb;
               launch = cpha_q ? lead_stb : (trail_stb && (edge_q != LAST_EDGE));
               if (sample) begin
                  rx_sh_d = (dir_q == MSB_FIRST) ? {rx_sh_q[DATA_WIDTH-2:0], miso0}
                                                 : {miso0, rx_sh_q[DATA_WIDTH-1:1]};
               end
               if (launch) begin
                  mosi_d  = (dir_q == MSB_FIRST) ? tx_sh_q[DATA_WIDTH-1] : tx_sh_q[0];
                  tx_sh_d = (dir_q == MSB_FIRST) ? (tx_sh_q << 1) : (tx_sh_q >> 1);
               end
               if (edge_q == LAST_EDGE) begin
                  state_d = HOLD;
                  edge_d  = '0;
               end else begin
                  edge_d = edge_q + EDGE_W'(1);
               end
            end
         end
         HOLD: begin
            if (dly_cnt_q == dly_last) begin
               state_d   = GAP;
               dly_cnt_d = '0;
               rx_data_d = rx_sh_q;
            end else begin
               dly_cnt_d = dly_cnt_q + DIV_WIDTH'(1);
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      sel_mask = '1;
      for (int unsigned i = 0; i < NO_OF_SLAVES; i++) begin
         if (sel_d == SEL_WIDTH'(i)) sel_mask[i] = 1'b0;
      end

      // Outputs are computed from the next state so every port is a flop.
      cs_d       = (state_d inside {SETUP, SHIFT, HOLD}) ? sel_mask : '1;
      rx_valid_d = (state_d == GAP);
      tx_ready_d = (state_d == IDLE);
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge pclk) begin
      if (areset) begin
         state_q    <= IDLE;
         dir_q      <= MSB_FIRST;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         div_q      <= DIV_WIDTH'(1);
         dly_q      <= DIV_WIDTH'(1);
         dly_cnt_q  <= '0;
         sel_q      <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         edge_q     <= '0;
         cs_q       <= '1;
         mosi_q     <= 1'b0;
         tx_ready_q <= 1'b0;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         cpol_q     <= cpol_d;
         cpha_q     <= cpha_d;
         div_q      <= div_d;
         dly_q      <= dly_d;
         dly_cnt_q  <= dly_cnt_d;
         sel_q      <= sel_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         rx_data_q  <= rx_data_d;
         edge_q     <= edge_d;
         cs_q       <= cs_d;
         mosi_q     <= mosi_d;
         tx_ready_q <= tx_ready_d;
         rx_valid_q <= rx_valid_d;
         busy_q     <= busy_d;
      end
   end

   assign tx_ready = tx_ready_q;
   assign rx_valid = rx_valid_q;
   assign rx_data  = rx_data_q;
   assign busy     = busy_q;
   assign cs       = cs_q;
   assign mosi0    = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural SPI slave on two CS lines.
module tb_spi_master_ctrl;

   logic       pclk = 1'b0;
   logic       areset = 1'b1;
   logic       cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_msb_first = 1'b1;
   logic [7:0] cfg_baud_div = 8'd2, cfg_cs_delay = 8'd1;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] tx_data = '0;
   logic [1:0] tx_slave_sel = '0;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       busy, sclk, mosi0;
   logic [1:0] cs;
   logic       miso0 = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rxv_count = 0;

   spi_master_ctrl #(
      .DATA_WIDTH   (8),
      .NO_OF_SLAVES (2),
      .DIV_WIDTH    (8),
      .SEL_WIDTH    (2)
   ) dut (
      .pclk          (pclk),
      .areset        (areset),
      .cfg_cpol      (cfg_cpol),
      .cfg_cpha      (cfg_cpha),
      .cfg_msb_first (cfg_msb_first),
      .cfg_baud_div  (cfg_baud_div),
      .cfg_cs_delay  (cfg_cs_delay),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .tx_data       (tx_data),
      .tx_slave_sel  (tx_slave_sel),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .busy          (busy),
      .sclk          (sclk),
      .cs            (cs),
      .mosi0         (mosi0),
      .miso0         (miso0)
   );

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc <= cyc + 1;
   always @(negedge pclk) if (rx_valid === 1'b1) rxv_count++;

   // Behavioural slave: drives MISO and captures MOSI according to its own mode.
   logic       s_cpol = 1'b0, s_cpha = 1'b0, s_msb = 1'b1;
   logic [7:0] slv_tx = '0, slv_sh = '0, slv_rx = '0;
   logic       slv_act = 1'b0, sclk_prev = 1'b0;
   int         tb_edges = 0;

   always @(cs or sclk) begin
      if (cs != 2'b11 && !slv_act) begin
         slv_act  = 1'b1;
         slv_sh   = slv_tx;
         slv_rx   = '0;
         tb_edges = 0;
         if (!s_cpha) begin
            miso0  = s_msb ? slv_sh[7] : slv_sh[0];
            slv_sh = s_msb ? (slv_sh << 1) : (slv_sh >> 1);
         end
      end else if (cs == 2'b11) begin
         slv_act = 1'b0;
      end else if (sclk !== sclk_prev) begin
         tb_edges++;
         if ((sclk != s_cpol) == s_cpha) begin
            miso0  = s_msb ? slv_sh[7] : slv_sh[0];
            slv_sh = s_msb ? (slv_sh << 1) : (slv_sh >> 1);
         end else begin
            slv_rx = s_msb ? {slv_rx[6:0], mosi0} : {mosi0, slv_rx[7:1]};
         end
      end
      sclk_prev = sclk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_mode(input logic cpol, input logic cpha, input logic msb,
                           input logic [7:0] div, input logic [7:0] dly);
      cfg_cpol = cpol; cfg_cpha = cpha; cfg_msb_first = msb;
      cfg_baud_div = div; cfg_cs_delay = dly;
      s_cpol = cpol; s_cpha = cpha; s_msb = msb;
      @(negedge pclk);
      @(negedge pclk);
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 200; i++) begin
         if (tx_ready === 1'b1) break;
         @(negedge pclk);
      end
   endtask

   // Runs one transfer; all cycle numbers are relative to the accept cycle 0.
   task automatic run_xfer(input logic [7:0] data, input logic [1:0] sel, input logic [7:0] slave_word,
                           output int cs_first, output int cs_last, output int rxv_rel,
                           output int sclk_first, output logic [7:0] rxd, output logic [7:0] cap,
                           output logic [1:0] cs_seen, output int edges);
      int base;
      int rel;
      slv_tx = slave_word;
      wait_ready();
      tx_valid = 1'b1; tx_data = data; tx_slave_sel = sel;
      base = cyc;
      cs_first = -1; cs_last = -1; rxv_rel = -1; sclk_first = -1;
      rxd = '0; cap = '0; cs_seen = 2'b11; edges = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge pclk);
         tx_valid = 1'b0;
         rel = cyc - base;
         if (cs != 2'b11) begin
            if (cs_first < 0) begin
               cs_first = rel;
               cs_seen  = cs;
            end
            cs_last = rel;
            if (sclk_first < 0 && sclk != s_cpol) sclk_first = rel;
         end
         if (rx_valid === 1'b1) begin
            rxv_rel = rel; rxd = rx_data; cap = slv_rx; edges = tb_edges;
            break;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   int         cf, cl, rv, sf, ed, rel, base, cs2_start, rx_seen, rxv_before;
   logic [7:0] rd, cp, rd2, cp2, cap1;
   logic [1:0] csv;
   logic       gap_ok;

   initial begin
      // Reset state
      repeat (3) @(negedge pclk);
      check("rst_sclk", sclk, 1'b0);
      check("rst_cs", cs, 2'b11);
      check("rst_mosi", mosi0, 1'b0);
      check("rst_tx_ready", tx_ready, 1'b0);
      check("rst_rx_valid", rx_valid, 1'b0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_busy", busy, 1'b0);
      areset = 1'b0;
      @(negedge pclk);
      check("rst_ready_after", tx_ready, 1'b1);

      // Mode 0, MSB-first, N=2, D=1
      set_mode(1'b0, 1'b0, 1'b1, 8'd2, 8'd1);
      run_xfer(8'hA5, 2'd0, 8'h3C, cf, cl, rv, sf, rd, cp, csv, ed);
      check("m0_cs_first", cf, 1);
      check("m0_cs_last", cl, 34);
      check("m0_cs_value", csv, 2'b10);
      check("m0_edge1", sf, 4);
      check("m0_rxv_cycle", rv, 35);
      check("m0_rx_data", rd, 8'h3C);
      check("m0_slave_cap", cp, 8'hA5);
      check("m0_edges", ed, 16);
      @(negedge pclk);
      check("m0_ready_36", tx_ready, 1'b1);
      check("m0_busy_36", busy, 1'b0);

      // Mode 3, LSB-first
      set_mode(1'b1, 1'b1, 1'b0, 8'd2, 8'd1);
      check("m3_sclk_idle", sclk, 1'b1);
      run_xfer(8'h81, 2'd0, 8'hF0, cf, cl, rv, sf, rd, cp, csv, ed);
      check("m3_cs_first", cf, 1);
      check("m3_edge1", sf, 4);
      check("m3_rxv_cycle", rv, 35);
      check("m3_rx_data", rd, 8'hF0);
      check("m3_slave_cap", cp, 8'h81);
      check("m3_edges", ed, 16);
      @(negedge pclk);
      check("m3_sclk_after", sclk, 1'b1);

      // Back-to-back with tx_valid held; config wiggled mid-transfer
      set_mode(1'b0, 1'b0, 1'b1, 8'd2, 8'd1);
      slv_tx = 8'h96;
      wait_ready();
      tx_valid = 1'b1; tx_data = 8'h11; tx_slave_sel = 2'd0;
      base = cyc; cs2_start = -1; rx_seen = 0; gap_ok = 1'b1;
      cap1 = '0; cp2 = '0; rd2 = '0;
      for (int i = 0; i < 80; i++) begin
         @(negedge pclk);
         rel = cyc - base;
         if (rel == 1) tx_data = 8'h22;
         if (rel == 10) begin cfg_baud_div = 8'd5; cfg_cpha = 1'b1; cfg_msb_first = 1'b0; end
         if (rel == 30) begin cfg_baud_div = 8'd2; cfg_cpha = 1'b0; cfg_msb_first = 1'b1; end
         if (rel == 37) tx_valid = 1'b0;
         if ((rel == 35 || rel == 36) && cs != 2'b11) gap_ok = 1'b0;
         if (rel > 35 && cs2_start < 0 && cs != 2'b11) cs2_start = rel;
         if (rx_valid === 1'b1) begin
            rx_seen++;
            if (rx_seen == 1) begin
               check("b2b_rx1_cycle", rel, 35);
               cap1 = slv_rx;
            end else begin
               check("b2b_rx2_cycle", rel, 71);
               cp2 = slv_rx; rd2 = rx_data;
            end
         end
      end
      tx_valid = 1'b0;
      check("b2b_cs_gap", gap_ok, 1'b1);
      check("b2b_cs2_start", cs2_start, 37);
      check("b2b_rx_count", rx_seen, 2);
      check("b2b_cap1", cap1, 8'h11);
      check("b2b_cap2", cp2, 8'h22);
      check("b2b_rx2_data", rd2, 8'h96);

      // Zero divider and delay behave as 1 (mode 1)
      set_mode(1'b0, 1'b1, 1'b1, 8'd0, 8'd0);
      run_xfer(8'hC3, 2'd0, 8'h5A, cf, cl, rv, sf, rd, cp, csv, ed);
      check("z_cs_first", cf, 1);
      check("z_cs_last", cl, 18);
      check("z_edge1", sf, 3);
      check("z_rxv_cycle", rv, 19);
      check("z_edges", ed, 16);
      check("z_rx_data", rd, 8'h5A);
      check("z_slave_cap", cp, 8'hC3);

      // Reset in the middle of a transfer
      set_mode(1'b0, 1'b0, 1'b1, 8'd2, 8'd1);
      slv_tx = 8'h77;
      wait_ready();
      tx_valid = 1'b1; tx_data = 8'hC6; tx_slave_sel = 2'd0;
      @(negedge pclk);
      tx_valid = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (tb_edges >= 5) break;
         @(negedge pclk);
      end
      check("ar_edge5", tb_edges, 5);
      rxv_before = rxv_count;
      areset = 1'b1;
      @(negedge pclk);
      check("ar_cs", cs, 2'b11);
      check("ar_sclk", sclk, 1'b0);
      check("ar_mosi", mosi0, 1'b0);
      check("ar_busy", busy, 1'b0);
      check("ar_tx_ready", tx_ready, 1'b0);
      check("ar_rx_data", rx_data, 8'h00);
      areset = 1'b0;
      @(negedge pclk);
      check("ar_ready_after", tx_ready, 1'b1);
      repeat (40) @(negedge pclk);
      check("ar_no_rx_valid", rxv_count, rxv_before);
      run_xfer(8'h5A, 2'd0, 8'hE7, cf, cl, rv, sf, rd, cp, csv, ed);
      check("ar_next_rxv", rv, 35);
      check("ar_next_rx_data", rd, 8'hE7);
      check("ar_next_cap", cp, 8'h5A);

      // Slave select: index 1, then out of range
      run_xfer(8'h3E, 2'd1, 8'h42, cf, cl, rv, sf, rd, cp, csv, ed);
      check("sel1_cs", csv, 2'b01);
      check("sel1_rx_data", rd, 8'h42);
      run_xfer(8'h99, 2'd2, 8'h00, cf, cl, rv, sf, rd, cp, csv, ed);
      check("sel2_cs_never_low", cf, -1);
      check("sel2_rxv_cycle", rv, 35);
      @(negedge pclk);
      check("sel2_rx_valid_pulse", rx_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
